// File: rtl/maze_pkg.sv
// Shared maze definitions: direction encoding, FSM states and the single
// location-step function used by both the forward datapath and the backtracker.
package maze_pkg;

   typedef enum logic [1:0] {
      DIR_YM = 2'b00,
      DIR_XP = 2'b01,
      DIR_XM = 2'b10,
      DIR_YP = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      REPLAY = 2'b01,
      DONE   = 2'b10
   } state_t;

   // Axis select is dir[1]^dir[0] (1 = X); sign is dir[0] (1 = +1). Coordinates wrap mod 16.
   function automatic logic [7:0] step(input logic [7:0] loc, input logic [1:0] dir);
      logic [3:0] x;
      logic [3:0] y;
      x = loc[7:4];
      y = loc[3:0];
      if (dir[1] ^ dir[0]) begin
         x = dir[0] ? x + 4'd1 : x - 4'd1;
      end else begin
         y = dir[0] ? y + 4'd1 : y - 4'd1;
      end
      return {x, y};
   endfunction

   function automatic logic [1:0] inv_dir(input logic [1:0] dir);
      return ~dir;
   endfunction

endpackage

// File: rtl/maze_backtrack_dir_stack.sv
// LIFO of 2-bit move directions: synchronous write, combinational read of the top entry.
// Pop wins over push when both are requested; clr empties the stack.
module dir_stack #(
   parameter int DEPTH = 256,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push_en,
   input  logic             pop_en,
   input  logic [1:0]       wdata,
   output logic [1:0]       top,
   output logic [PTR_W-1:0] sp,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] sp_q;
   logic [PTR_W-1:0] sp_d;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic             do_push;

   assign wr_idx  = sp_q[AW-1:0];
   assign rd_idx  = wr_idx - AW'(1);
   assign top     = mem_q[rd_idx];
   assign sp      = sp_q;
   assign full    = (sp_q == PTR_W'(DEPTH));
   assign empty   = (sp_q == '0);
   assign do_push = push_en && !pop_en && !clr && !full;

   always_comb begin
      sp_d = sp_q;
      if (clr) begin
         sp_d = '0;
      end else if (pop_en && !empty) begin
         sp_d = sp_q - PTR_W'(1);
      end else if (do_push) begin
         sp_d = sp_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   // Contents need no reset: only entries below sp are ever read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= wdata;
      end
   end

endmodule

// File: rtl/maze_backtrack.sv
// Move recorder / backtracker: logs forward moves on a LIFO and retraces them
// by stepping the location register in the inverse direction.
//
//   state  | meaning
//   IDLE   | accept ld / replay / pop / push (that priority)
//   REPLAY | pop one move per cycle until the stack is empty
//   DONE   | one-cycle tail that raises done, then back to IDLE
module maze_backtrack
   import maze_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld,
   input  logic [7:0] loc_in,
   input  logic       push,
   input  logic [1:0] dir_in,
   input  logic       pop,
   input  logic       replay,
   output logic [7:0] loc_out,
   output logic [1:0] pop_dir,
   output logic       out_valid,
   output logic       empty,
   output logic       full,
   output logic       busy,
   output logic       done,
   output logic       overflow,
   output logic       underflow
);

   localparam int PTR_W = $clog2(DEPTH) + 1;

   state_t           state_q, state_d;
   logic [7:0]       loc_q, loc_d;
   logic [1:0]       pop_dir_q, pop_dir_d;
   logic             out_valid_q, out_valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             clr, push_en, pop_en;
   logic [1:0]       top;
   logic [PTR_W-1:0] sp;

   dir_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_stack (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .push_en (push_en),
      .pop_en  (pop_en),
      .wdata   (dir_in),
      .top     (top),
      .sp      (sp),
      .full    (full),
      .empty   (empty)
   );

   always_comb begin
      state_d     = state_q;
      loc_d       = loc_q;
      pop_dir_d   = pop_dir_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      clr         = 1'b0;
      push_en     = 1'b0;
      pop_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (ld) begin
               loc_d       = loc_in;
               clr         = 1'b1;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
            end else if (replay) begin
               state_d = empty ? DONE : REPLAY;
            end else if (pop) begin
               if (!empty) pop_en = 1'b1;
               else        underflow_d = 1'b1;
            end else if (push) begin
               if (!full) begin
                  push_en = 1'b1;
                  loc_d   = step(loc_q, dir_in);
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         REPLAY: begin
            pop_en = 1'b1;
            if (sp == PTR_W'(1)) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Single-step pop and replay share the same undo path.
      if (pop_en) begin
         loc_d       = step(loc_q, inv_dir(top));
         pop_dir_d   = top;
         out_valid_d = 1'b1;
      end
      busy_d = (state_d == REPLAY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         loc_q       <= 8'h00;
         pop_dir_q   <= 2'b00;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         loc_q       <= loc_d;
         pop_dir_q   <= pop_dir_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign loc_out   = loc_q;
   assign pop_dir   = pop_dir_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_maze_backtrack.sv
// Directed bench for maze_backtrack: expected undo results are queued at stimulus
// time and a negedge monitor pops and compares them against out_valid / done.
module tb_maze_backtrack;

   typedef struct {
      logic [7:0] loc;
      logic [1:0] dir;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld = 1'b0, push = 1'b0, pop = 1'b0, replay = 1'b0;
   logic [7:0] loc_in = 8'h00;
   logic [1:0] dir_in = 2'b00;
   logic [7:0] loc_out;
   logic [1:0] pop_dir;
   logic       out_valid, empty, full, busy, done, overflow, underflow;

   logic       s_ld = 1'b0, s_push = 1'b0, s_pop = 1'b0, s_replay = 1'b0;
   logic [7:0] s_loc_in = 8'h00;
   logic [1:0] s_dir_in = 2'b00;
   logic [7:0] s_loc_out;
   logic [1:0] s_pop_dir;
   logic       s_out_valid, s_empty, s_full, s_busy, s_done, s_overflow, s_underflow;

   int         total = 0;
   int         passed = 0;
   int         busy_cycles = 0;
   int         done_seen = 0;
   exp_t       exp_q[$];
   logic [7:0] done_q[$];

   always #5 clk = ~clk;

   maze_backtrack dut (
      .clk(clk), .rst(rst), .ld(ld), .loc_in(loc_in), .push(push), .dir_in(dir_in),
      .pop(pop), .replay(replay), .loc_out(loc_out), .pop_dir(pop_dir),
      .out_valid(out_valid), .empty(empty), .full(full), .busy(busy), .done(done),
      .overflow(overflow), .underflow(underflow)
   );

   maze_backtrack #(.DEPTH(4)) dut_small (
      .clk(clk), .rst(rst), .ld(s_ld), .loc_in(s_loc_in), .push(s_push), .dir_in(s_dir_in),
      .pop(s_pop), .replay(s_replay), .loc_out(s_loc_out), .pop_dir(s_pop_dir),
      .out_valid(s_out_valid), .empty(s_empty), .full(s_full), .busy(s_busy), .done(s_done),
      .overflow(s_overflow), .underflow(s_underflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ld(input logic [7:0] l);
      ld = 1'b1; loc_in = l;
      tick();
      ld = 1'b0;
      chk("ld_loc", int'(loc_out), int'(l));
   endtask

   task automatic do_push(input logic [1:0] d, input logic [7:0] exp_loc);
      push = 1'b1; dir_in = d;
      tick();
      push = 1'b0;
      chk("push_loc", int'(loc_out), int'(exp_loc));
   endtask

   task automatic do_pop(input logic [7:0] exp_loc, input logic [1:0] exp_dir);
      exp_t e;
      e.loc = exp_loc; e.dir = exp_dir;
      exp_q.push_back(e);
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int start;
      bit seen;
      start = done_seen;
      seen  = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (done_seen != start) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         total++;
         $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_out_valid: got out_valid loc %0h expected none", loc_out);
            end else begin
               e = exp_q.pop_front();
               chk("pop_loc", int'(loc_out), int'(e.loc));
               chk("pop_dir", int'(pop_dir), int'(e.dir));
            end
         end
         if (done) begin
            done_seen++;
            if (done_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_done: got done loc %0h expected none", loc_out);
            end else begin
               chk("done_loc", int'(loc_out), int'(done_q.pop_front()));
            end
         end
      end
   end

   initial begin : stim
      repeat (2) tick();
      rst = 1'b0;
      chk("rst_loc", int'(loc_out), 8'h00);
      chk("rst_pop_dir", int'(pop_dir), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_unf", int'(underflow), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);

      // Load / step / undo
      do_ld(8'h55);
      do_push(2'b01, 8'h65);
      do_push(2'b01, 8'h75);
      do_push(2'b11, 8'h76);
      chk("stk_empty_after_push", int'(empty), 0);
      do_pop(8'h75, 2'b11);
      do_pop(8'h65, 2'b01);
      do_pop(8'h55, 2'b01);
      tick();
      chk("empty_after_pops", int'(empty), 1);

      // Wrap-around
      do_ld(8'h0F);
      do_push(2'b11, 8'h00);
      do_push(2'b10, 8'hF0);
      do_pop(8'h00, 2'b10);
      do_pop(8'h0F, 2'b11);
      tick();

      // Replay of 5 entries
      do_ld(8'h33);
      do_push(2'b00, 8'h32);
      do_push(2'b00, 8'h31);
      do_push(2'b10, 8'h21);
      do_push(2'b01, 8'h31);
      do_push(2'b11, 8'h32);
      exp_q.push_back('{loc: 8'h31, dir: 2'b11});
      exp_q.push_back('{loc: 8'h21, dir: 2'b01});
      exp_q.push_back('{loc: 8'h31, dir: 2'b10});
      exp_q.push_back('{loc: 8'h32, dir: 2'b00});
      exp_q.push_back('{loc: 8'h33, dir: 2'b00});
      done_q.push_back(8'h33);
      busy_cycles = 0;
      replay = 1'b1;
      tick();
      replay = 1'b0;
      wait_done(20);
      tick();
      chk("replay_busy_cycles", busy_cycles, 5);
      chk("replay_final_loc", int'(loc_out), 8'h33);
      chk("replay_empty", int'(empty), 1);
      chk("replay_busy_end", int'(busy), 0);

      // Pop on empty
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();
      chk("underflow_set", int'(underflow), 1);
      chk("underflow_loc", int'(loc_out), 8'h33);

      // Replay on empty
      done_q.push_back(8'h33);
      replay = 1'b1;
      tick();
      replay = 1'b0;
      wait_done(5);
      tick();

      // Simultaneous push and pop: pop wins
      do_ld(8'h33);
      chk("ld_clears_unf", int'(underflow), 0);
      do_push(2'b01, 8'h43);
      do_push(2'b11, 8'h44);
      exp_q.push_back('{loc: 8'h43, dir: 2'b11});
      push = 1'b1; pop = 1'b1; dir_in = 2'b01;
      tick();
      push = 1'b0; pop = 1'b0;
      chk("simul_not_empty", int'(empty), 0);
      do_pop(8'h33, 2'b01);
      tick();
      chk("simul_empty", int'(empty), 1);

      // Overflow on a 4-deep instance
      s_ld = 1'b1; s_loc_in = 8'h00;
      tick();
      s_ld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_push = 1'b1; s_dir_in = 2'b01;
         tick();
      end
      s_push = 1'b0;
      chk("small_full", int'(s_full), 1);
      chk("small_loc4", int'(s_loc_out), 8'h40);
      chk("small_ovf_pre", int'(s_overflow), 0);
      s_push = 1'b1; s_dir_in = 2'b11;
      tick();
      s_push = 1'b0;
      chk("small_ovf", int'(s_overflow), 1);
      chk("small_ovf_loc", int'(s_loc_out), 8'h40);
      chk("small_ovf_full", int'(s_full), 1);

      // Reset during the second REPLAY cycle
      do_ld(8'h33);
      do_push(2'b01, 8'h43);
      do_push(2'b01, 8'h53);
      do_push(2'b01, 8'h63);
      do_push(2'b01, 8'h73);
      do_push(2'b01, 8'h83);
      exp_q.push_back('{loc: 8'h73, dir: 2'b01});
      replay = 1'b1;
      tick();
      replay = 1'b0;
      tick();
      chk("mid_replay_busy", int'(busy), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_loc", int'(loc_out), 8'h00);
      chk("abort_busy", int'(busy), 0);
      chk("abort_empty", int'(empty), 1);
      repeat (4) tick();
      do_push(2'b11, 8'h01);
      do_pop(8'h00, 2'b11);
      repeat (3) tick();

      chk("exp_q_drained", exp_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
